// File: rtl/sram_bist_pkg.sv
// March C- BIST definitions: FSM states, op codes and the element table.
// Op code bit 1 = read, bit 0 = data background (0 -> all-zero, 1 -> all-one).
package sram_bist_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] OP_W0 = 2'b00;
    localparam logic [1:0] OP_W1 = 2'b01;
    localparam logic [1:0] OP_R0 = 2'b10;
    localparam logic [1:0] OP_R1 = 2'b11;

    localparam int         NUM_ELEM  = 6;
    localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

    // Element tables, index = element number (E5 listed first in each literal)
    localparam logic [NUM_ELEM-1:0] ELEM_DOWN    = 6'b011000;
    localparam logic [NUM_ELEM-1:0] ELEM_TWO_OPS = 6'b011110;
    localparam logic [NUM_ELEM-1:0][1:0] ELEM_OP0 = {OP_R0, OP_R1, OP_R0, OP_R1, OP_R0, OP_W0};
    localparam logic [NUM_ELEM-1:0][1:0] ELEM_OP1 = {OP_W0, OP_W0, OP_W1, OP_W0, OP_W1, OP_W0};

    function automatic logic op_is_read(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_value(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/sram_1p_march_bist_if.sv
// Control/status and macro BIST-port bundle between the March engine (master) and the SRAM side (slave).
// Pure wiring: no latency, no flow control.
interface sram_1p_march_bist_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11
);
    logic              A_START;
    logic              A_BUSY;
    logic              A_DONE;
    logic              A_FAIL;
    logic              A_BIST_EN;
    logic              A_BIST_MEN;
    logic              A_BIST_WEN;
    logic              A_BIST_REN;
    logic [ADDR_W-1:0] A_BIST_ADDR;
    logic [DATA_W-1:0] A_BIST_DIN;
    logic [DATA_W-1:0] A_BIST_BM;
    logic [DATA_W-1:0] A_DOUT;
    logic [ADDR_W-1:0] A_FAIL_ADDR;
    logic [2:0]        A_FAIL_ELEM;

    modport master (
        input  A_START, A_DOUT,
        output A_BUSY, A_DONE, A_FAIL, A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
               A_BIST_ADDR, A_BIST_DIN, A_BIST_BM, A_FAIL_ADDR, A_FAIL_ELEM
    );

    modport slave (
        output A_START, A_DOUT,
        input  A_BUSY, A_DONE, A_FAIL, A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
               A_BIST_ADDR, A_BIST_DIN, A_BIST_BM, A_FAIL_ADDR, A_FAIL_ELEM
    );
endinterface

// File: rtl/sram_bist_cmp.sv
// Read-check pipeline: captures read-valid and expected background with the read, compares A_DOUT next cycle.
// Latency: mismatch pulse one cycle after the read op; never stalls.
module sram_bist_cmp #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_vld,
    input  logic              rd_exp,
    input  logic [DATA_W-1:0] dout,
    output logic              mismatch
);

    logic rd_vld_q;
    logic exp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            exp_q    <= 1'b0;
        end else begin
            rd_vld_q <= rd_vld;
            exp_q    <= rd_exp;
        end
    end

    assign mismatch = rd_vld_q && (dout != {DATA_W{exp_q}});

endmodule

// File: rtl/sram_1p_march_bist.sv
// March C- self-test engine for a single-port SRAM BIST port; 10*DEPTH op cycles + drain, one op per cycle.
// Optional first-fail diagnosis under SRAM_BIST_DIAG_EN (A_FAIL_ADDR/A_FAIL_ELEM tied 0 otherwise).
module sram_1p_march_bist
    import sram_bist_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic                 A_CLK,
    input  logic                 A_RST,
    sram_1p_march_bist_if.master bist
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [2:0]        elem;
    logic              op_idx;
    logic [ADDR_W-1:0] addr;
    logic              fail_q;

    logic              run;
    logic              busy;
    logic              start_acc;
    logic [1:0]        cur_op;
    logic              last_op;
    logic              down;
    logic              addr_end;
    logic [2:0]        next_elem;
    logic              mismatch;

    assign run       = (state == ST_RUN);
    assign busy      = run || (state == ST_DRAIN);
    assign start_acc = (state == ST_IDLE) && bist.A_START;
    assign cur_op    = op_idx ? ELEM_OP1[elem] : ELEM_OP0[elem];
    assign last_op   = !ELEM_TWO_OPS[elem] || op_idx;
    assign down      = ELEM_DOWN[elem];
    assign addr_end  = down ? (addr == '0) : (addr == LAST_ADDR);
    assign next_elem = elem + 3'd1;

    // Sequencer: op slot within an address, then address, then element
    always_ff @(posedge A_CLK or posedge A_RST) begin
        if (A_RST) begin
            state  <= ST_IDLE;
            elem   <= '0;
            op_idx <= 1'b0;
            addr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bist.A_START) begin
                        state  <= ST_RUN;
                        elem   <= '0;
                        op_idx <= 1'b0;
                        addr   <= '0;
                    end
                end
                ST_RUN: begin
                    if (!last_op) begin
                        op_idx <= 1'b1;
                    end else begin
                        op_idx <= 1'b0;
                        if (!addr_end) begin
                            addr <= down ? addr - 1'b1 : addr + 1'b1;
                        end else if (elem == LAST_ELEM) begin
                            state <= ST_DRAIN;
                            addr  <= '0;
                        end else begin
                            elem <= next_elem;
                            addr <= ELEM_DOWN[next_elem] ? LAST_ADDR : '0;
                        end
                    end
                end
                ST_DRAIN: state <= ST_DONE;
                ST_DONE: begin
                    state <= ST_IDLE;
                    elem  <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sram_bist_cmp #(
        .DATA_W(DATA_W)
    ) u_cmp (
        .clk     (A_CLK),
        .rst     (A_RST),
        .rd_vld  (run && op_is_read(cur_op)),
        .rd_exp  (op_value(cur_op)),
        .dout    (bist.A_DOUT),
        .mismatch(mismatch)
    );

    always_ff @(posedge A_CLK or posedge A_RST) begin
        if (A_RST) begin
            fail_q <= 1'b0;
        end else if (start_acc) begin
            fail_q <= 1'b0;
        end else if (mismatch) begin
            fail_q <= 1'b1;
        end
    end

`ifdef SRAM_BIST_DIAG_EN
    logic [ADDR_W-1:0] rd_addr_q;
    logic [2:0]        rd_elem_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [2:0]        fail_elem_q;

    // Tag follows the read into the compare cycle; only the first mismatch is kept
    always_ff @(posedge A_CLK or posedge A_RST) begin
        if (A_RST) begin
            rd_addr_q   <= '0;
            rd_elem_q   <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else begin
            rd_addr_q <= addr;
            rd_elem_q <= elem;
            if (start_acc) begin
                fail_addr_q <= '0;
                fail_elem_q <= '0;
            end else if (mismatch && !fail_q) begin
                fail_addr_q <= rd_addr_q;
                fail_elem_q <= rd_elem_q;
            end
        end
    end

    assign bist.A_FAIL_ADDR = fail_addr_q;
    assign bist.A_FAIL_ELEM = fail_elem_q;
`else
    assign bist.A_FAIL_ADDR = '0;
    assign bist.A_FAIL_ELEM = '0;
`endif

    assign bist.A_BUSY      = busy;
    assign bist.A_DONE      = (state == ST_DONE);
    assign bist.A_FAIL      = fail_q;
    assign bist.A_BIST_EN   = busy;
    assign bist.A_BIST_MEN  = run;
    assign bist.A_BIST_WEN  = run && !op_is_read(cur_op);
    assign bist.A_BIST_REN  = run && op_is_read(cur_op);
    assign bist.A_BIST_ADDR = run ? addr : '0;
    assign bist.A_BIST_DIN  = (run && op_value(cur_op)) ? '1 : '0;
    assign bist.A_BIST_BM   = busy ? '1 : '0;

endmodule
